tone_decoder: RTL and testbench
===============================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter TONE_DIV, default 5: clk cycles per tone tick (half-period measurement unit).
REQ-002 Parameter DUR_TICK, default 327680: clk cycles per duration unit.
REQ-003 Parameter REST_TIMEOUT, default 65535: tone ticks without an edge that declare silence.
REQ-004 Parameter TOL, default 2: max |new half-period - current half-period|, in tone ticks, still counted as the same note.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 i_tone  input  1  square-wave audio input, asynchronous to clk.
REQ-008 o_valid  output  1  note event available.
REQ-009 i_ready  input  1  consumer accepts event when high with o_valid.
REQ-010 o_period  output  16  event half-period in tone ticks; 0 = rest.
REQ-011 o_dur  output  16  event duration in DUR_TICK units.
REQ-012 o_overflow  output  1  sticky: an event was dropped.
REQ-013 o_debug  output  8  low byte of current locked half-period; 0 when not in TONE.

Function
REQ-014 i_tone SHALL pass a 2-flop synchronizer; an edge is any change of the synchronized value vs its previous cycle value.
REQ-015 A tone-tick strobe SHALL pulse once every TONE_DIV clk cycles, free-running from reset.
REQ-016 Half-period counter hp SHALL increment per tone tick, saturate at 0xFFFF, and clear to 0 on every edge; the value before clearing is the measurement m.
REQ-017 Duration counter SHALL count DUR_TICK-cycle units, saturate at 0xFFFF, and restart at 0 at every note/rest boundary.
REQ-018 FSM states: IDLE, LOCK, TONE, REST; reset state IDLE.
REQ-019 IDLE: first edge -> LOCK, duration restarts; no event emitted.
REQ-020 LOCK: next edge -> TONE with cur_p = m; duration not restarted (note starts at the LOCK-entry edge).
REQ-021 LOCK: hp reaches REST_TIMEOUT -> REST, duration restarts; no event emitted.
REQ-022 TONE: edge with |m - cur_p| <= TOL -> stay; cur_p unchanged.
REQ-023 TONE: edge with |m - cur_p| > TOL -> emit (cur_p, dur), cur_p = m, duration restarts, stay TONE.
REQ-024 TONE: hp reaches REST_TIMEOUT -> emit (cur_p, dur), REST, duration restarts.
REQ-025 REST: edge -> emit (0, dur), LOCK, duration restarts.
REQ-026 Events SHALL enter a 4-entry FIFO in emission order; o_valid = FIFO not empty; o_period/o_dur show head entry.
REQ-027 Pop on o_valid & i_ready; head data SHALL stay stable while o_valid & !i_ready.
REQ-028 Push to full FIFO without simultaneous pop SHALL drop the new event and set o_overflow until reset.
REQ-029 Simultaneous push and pop on full FIFO SHALL accept the push; no overflow.
REQ-030 Minimum latency emission-to-o_valid: 1 clk.

Reset
REQ-031 On rst low: FSM IDLE, hp, duration, prescaler, synchronizer, cur_p cleared; FIFO emptied.
REQ-032 Outputs during/after reset: o_valid 0, o_period 0, o_dur 0, o_overflow 0, o_debug 0.
REQ-033 Reset mid-note SHALL discard the partial note; no event emitted for it.

Verification (bench params TONE_DIV=5, DUR_TICK=100, REST_TIMEOUT=50, TOL=2, i_ready=1 unless noted)
REQ-034 Toggle i_tone every 50 clk for 41 edges, then hold -> one event period 10, dur 22 (+-1); o_debug 10 during tone, 0 after.
REQ-035 Half-periods 10,10,12,12 ticks then 13 -> no event at 12; event period 10 at the 13-tick edge; cur_p becomes 13.
REQ-036 After REQ-034 silence, 1000 clk more then edge -> rest event period 0, dur 10 (+-1); FSM in LOCK.
REQ-037 i_ready=0, generate 5 events -> o_overflow 1, o_valid held with first event stable; raise i_ready -> first four events popped in order, fifth absent.
REQ-038 Full FIFO, push and pop same cycle -> count stays 4, o_overflow stays 0.
REQ-039 Assert rst mid-TONE with 2 events queued -> all outputs 0 immediately; after release, first edge yields no event until LOCK/TONE sequence completes.

Source files
------------

// File: rtl/tone_decoder.sv
// tone_decoder: measures square-wave half-periods on i_tone, tracks note/rest
// segments with durations and queues completed events in a 4-deep FIFO.
module tone_decoder #(
    parameter int TONE_DIV     = 5,
    parameter int DUR_TICK     = 327680,
    parameter int REST_TIMEOUT = 65535,
    parameter int TOL          = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tone,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_period,
    output logic [15:0] o_dur,
    output logic        o_overflow,
    output logic [7:0]  o_debug
);
    typedef enum logic [1:0] {IDLE, LOCK, TONE, REST} state_t;

    localparam int PW = $clog2(TONE_DIV + 1);
    localparam int DW = $clog2(DUR_TICK + 1);

    state_t        state_q, state_d;
    logic [2:0]    sync_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dtick_q, dtick_d;
    logic [15:0]   hp_q, hp_d, m, diff, cur_p_q, cur_p_d, dur_q, dur_d, ev_p;
    logic          tone_edge, tick, dur_wrap, timeout, near, push, pop, full, wr_en, dur_rst;
    logic          ovf_q, ovf_d;
    logic [31:0]   mem_q [4];
    logic [1:0]    wr_q, rd_q;
    logic [2:0]    cnt_q, cnt_d;

    assign tone_edge = sync_q[1] ^ sync_q[2];
    assign tick      = presc_q == PW'(TONE_DIV - 1);
    assign presc_d   = tick ? '0 : presc_q + PW'(1);
    // A tick landing on the edge cycle still belongs to the measured half-period.
    assign m         = (tick && hp_q != 16'hFFFF) ? hp_q + 16'd1 : hp_q;
    assign hp_d      = tone_edge ? 16'd0 : m;
    assign timeout   = {16'd0, hp_q} >= 32'(REST_TIMEOUT);
    assign diff      = (m >= cur_p_q) ? m - cur_p_q : cur_p_q - m;
    assign near      = {16'd0, diff} <= 32'(TOL);
    assign dur_wrap  = dtick_q == DW'(DUR_TICK - 1);
    assign dtick_d   = (dur_rst || dur_wrap) ? '0 : dtick_q + DW'(1);
    assign dur_d     = dur_rst ? 16'd0 : (dur_wrap && dur_q != 16'hFFFF) ? dur_q + 16'd1 : dur_q;

    always_comb begin
        state_d = state_q;
        cur_p_d = cur_p_q;
        push    = 1'b0;
        ev_p    = cur_p_q;
        dur_rst = 1'b0;
        case (state_q)
            IDLE: if (tone_edge) begin
                state_d = LOCK;
                dur_rst = 1'b1;
            end
            LOCK: if (tone_edge) begin
                state_d = TONE;
                cur_p_d = m;
            end else if (timeout) begin
                state_d = REST;
                dur_rst = 1'b1;
            end
            TONE: if (tone_edge) begin
                if (!near) begin
                    push    = 1'b1;
                    cur_p_d = m;
                    dur_rst = 1'b1;
                end
            end else if (timeout) begin
                push    = 1'b1;
                state_d = REST;
                dur_rst = 1'b1;
            end
            REST: if (tone_edge) begin
                push    = 1'b1;
                ev_p    = 16'd0;
                state_d = LOCK;
                dur_rst = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop   = o_valid & i_ready;
    assign full  = cnt_q == 3'd4;
    assign wr_en = push & (~full | pop);
    assign cnt_d = cnt_q + 3'(wr_en) - 3'(pop);
    assign ovf_d = ovf_q | (push & full & ~pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            presc_q <= '0;
            dtick_q <= '0;
            hp_q    <= '0;
            cur_p_q <= '0;
            dur_q   <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], i_tone};
            presc_q <= presc_d;
            dtick_q <= dtick_d;
            hp_q    <= hp_d;
            cur_p_q <= cur_p_d;
            dur_q   <= dur_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_en ? wr_q + 2'd1 : wr_q;
            rd_q    <= pop ? rd_q + 2'd1 : rd_q;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= {ev_p, dur_q};
    end

    assign o_valid    = cnt_q != 3'd0;
    assign o_period   = o_valid ? mem_q[rd_q][31:16] : 16'd0;
    assign o_dur      = o_valid ? mem_q[rd_q][15:0] : 16'd0;
    assign o_overflow = ovf_q;
    assign o_debug    = (state_q == TONE) ? cur_p_q[7:0] : 8'd0;
endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed stimulus for tone_decoder with an event scoreboard
// filled at stimulus time and drained by a monitor on each accepted event.
module tb_tone_decoder;
    logic        clk = 1'b0, rst = 1'b0, i_tone = 1'b0, i_ready = 1'b1;
    logic        o_valid, o_overflow;
    logic [15:0] o_period, o_dur;
    logic [7:0]  o_debug;
    int          checks = 0, failures = 0;

    typedef struct {int p; int d; bit cd;} ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    always #5 clk = ~clk;

    tone_decoder #(.TONE_DIV(5), .DUR_TICK(100), .REST_TIMEOUT(50), .TOL(2)) dut (
        .clk(clk), .rst(rst), .i_tone(i_tone), .o_valid(o_valid), .i_ready(i_ready),
        .o_period(o_period), .o_dur(o_dur), .o_overflow(o_overflow), .o_debug(o_debug)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Toggle i_tone after a half-period of the given number of tone ticks.
    task automatic half(input int ticks);
        cyc(ticks * 5);
        i_tone = ~i_tone;
    endtask

    task automatic expect_ev(input int p, input int d, input bit cd);
        ev_t e;
        e.p = p; e.d = d; e.cd = cd;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        i_tone = 1'b0;
        i_ready = 1'b1;
        exp_q.delete();
        cyc(3);
        chk("rst_valid", o_valid, 0);
        chk("rst_period", o_period, 0);
        chk("rst_dur", o_dur, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_debug", o_debug, 0);
        rst = 1'b1;
        cyc(2);
    endtask

    always @(negedge clk) begin
        if (rst && o_valid && i_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_event observed=%0d/%0d expected=none", o_period, o_dur);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                assert (o_period === 16'(mon_e.p)) else begin
                    failures++;
                    $error("FAIL ev_period observed=%0d expected=%0d", o_period, mon_e.p);
                end
                if (mon_e.cd) begin
                    checks++;
                    assert (int'(o_dur) >= mon_e.d - 1 && int'(o_dur) <= mon_e.d + 1) else begin
                        failures++;
                        $error("FAIL ev_dur observed=%0d expected=%0d+-1", o_dur, mon_e.d);
                    end
                end
            end
        end
    end

    initial begin
        // Steady 10-tick tone for 41 edges, then silence.
        reset_dut();
        expect_ev(10, 22, 1'b1);
        i_tone = ~i_tone;
        for (int k = 0; k < 40; k++) begin
            half(10);
            if (k == 20) begin
                chk("debug_in_tone", o_debug, 10);
                chk("no_event_in_tone", o_valid, 0);
            end
        end
        drain("tone_event", 400);
        chk("debug_after_tone", o_debug, 0);
        // Rest of ~1000 clk ended by an edge.
        expect_ev(0, 10, 1'b1);
        cyc(1000);
        i_tone = ~i_tone;
        drain("rest_event", 20);
        chk("debug_in_lock", o_debug, 0);
        half(10);
        cyc(3);
        chk("lock_then_tone", o_debug, 10);

        // Drift within tolerance, then a real pitch change.
        reset_dut();
        i_tone = ~i_tone;
        half(10);
        half(10);
        half(12);
        half(12);
        chk("no_event_at_12", o_valid, 0);
        chk("cur_p_held", o_debug, 10);
        expect_ev(10, 2, 1'b1);
        half(13);
        drain("change_event", 20);
        chk("cur_p_13", o_debug, 13);

        // Five events with consumer stalled: fifth is dropped.
        reset_dut();
        i_ready = 1'b0;
        i_tone = ~i_tone;
        half(10);
        expect_ev(10, 0, 1'b0);
        half(20);
        expect_ev(20, 0, 1'b0);
        half(30);
        chk("hold_valid", o_valid, 1);
        chk("hold_head", o_period, 10);
        expect_ev(30, 0, 1'b0);
        half(40);
        expect_ev(40, 0, 1'b0);
        half(15);
        half(25);
        chk("no_ovf_at_four", o_overflow, 0);
        cyc(5);
        chk("ovf_set", o_overflow, 1);
        chk("stall_valid", o_valid, 1);
        chk("stall_head", o_period, 10);
        i_ready = 1'b1;
        drain("ovf_drain", 20);
        cyc(2);
        chk("fifth_absent", o_valid, 0);
        chk("ovf_sticky", o_overflow, 1);

        // Push and pop together on a full FIFO.
        reset_dut();
        i_ready = 1'b0;
        i_tone = ~i_tone;
        half(10);
        expect_ev(10, 0, 1'b0);
        half(20);
        expect_ev(20, 0, 1'b0);
        half(30);
        expect_ev(30, 0, 1'b0);
        half(40);
        expect_ev(40, 0, 1'b0);
        half(15);
        expect_ev(15, 0, 1'b0);
        cyc(125);
        i_tone = ~i_tone;
        cyc(2);
        i_ready = 1'b1;
        cyc(1);
        i_ready = 1'b0;
        cyc(3);
        chk("pushpop_ovf", o_overflow, 0);
        chk("pushpop_valid", o_valid, 1);
        chk("pushpop_head", o_period, 20);
        i_ready = 1'b1;
        drain("pushpop_drain", 20);
        cyc(2);
        chk("pushpop_empty", o_valid, 0);
        chk("pushpop_ovf_end", o_overflow, 0);

        // Reset mid-note with two events queued.
        reset_dut();
        i_ready = 1'b0;
        i_tone = ~i_tone;
        half(10);
        half(20);
        half(30);
        cyc(20);
        chk("pre_rst_valid", o_valid, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_period", o_period, 0);
        chk("mid_rst_dur", o_dur, 0);
        chk("mid_rst_overflow", o_overflow, 0);
        chk("mid_rst_debug", o_debug, 0);
        exp_q.delete();
        i_tone = 1'b0;
        cyc(3);
        rst = 1'b1;
        i_ready = 1'b1;
        cyc(2);
        i_tone = ~i_tone;
        half(10);
        half(10);
        chk("post_rst_no_event", o_valid, 0);
        chk("post_rst_tone", o_debug, 10);
        expect_ev(10, 3, 1'b1);
        drain("post_rst_event", 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
